// File: rtl/seg7_pkg.sv
// Shared seven-segment types and the active-low hex glyph table (segments g..a).
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    localparam seg7_t SEG7_ENC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = SEG7_ENC[nibble_i];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Registered multi-digit hex display controller with per-digit blink.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic [4*NUM_DIGITS-1:0] shown_value,
    output logic                    blink_phase
);

    localparam int               DIV_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic [DIV_W-1:0]        div_q;
    logic                    phase_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic [NUM_DIGITS-1:0]   lz_blank;
    seg7_t                   enc_w [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_digit_enc u_enc (
            .nibble_i (value_q[4*g +: 4]),
            .seg_o    (enc_w[g])
        );
    end

`ifdef SEG7_LZ_BLANK_EN
    logic zero_above;
`endif

    always_comb begin
        lz_blank = '0;
        seg_d    = '0;
`ifdef SEG7_LZ_BLANK_EN
        // Walk down from the top digit; a digit is leading while everything above it is zero.
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (value_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((phase_q && mask_q[i]) || lz_blank[i])
                seg_d[7*i +: 7] = SEG7_BLANK;
            else
                seg_d[7*i +: 7] = enc_w[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            mask_q  <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG7_LZ_BLANK_EN
                seg_q[7*i +: 7] <= (i == 0) ? SEG7_ENC[0] : SEG7_BLANK;
`else
                seg_q[7*i +: 7] <= SEG7_ENC[0];
`endif
            end
        end else begin
            seg_q <= seg_d;
            // A load restarts the blink cycle on its visible half, overriding any wrap.
            if (load) begin
                value_q <= value;
                mask_q  <= blink_en;
                div_q   <= '0;
                phase_q <= 1'b0;
            end else if (div_q == DIV_LAST) begin
                div_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                div_q   <= div_q + DIV_W'(1);
            end
        end
    end

    assign seg         = seg_q;
    assign shown_value = value_q;
    assign blink_phase = phase_q;

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Registered, parametrised multi-digit hex display controller for the board's common-anode seven-segment displays. It captures a packed hex value on a load strobe and drives one active-low 7-bit segment pattern per digit. It adds a per-digit blink function driven by an internal divider, with optional leading-zero blanking. It sits between datapath/debug registers and the HEX pin outputs, and replaces direct per-byte combinational decoding.

## Interface
- `NUM_DIGITS`, default 6: number of displayed hex digits, ≥1.
- `BLINK_DIV`, default 25_000_000: blink half-period in clock cycles, ≥1. At 50 MHz the default gives 1 Hz.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: capture `value` and `blink_en` this cycle.
- `value` in 4·NUM_DIGITS: packed nibbles; digit i = `value[4i+3:4i]`, where digit 0 is the rightmost.
- `blink_en` in NUM_DIGITS: bit i=1 makes digit i blink.
- `seg` out 7·NUM_DIGITS: digit i = `seg[7i+6:7i]`; active-low segments g..a, registered.
- `shown_value` out 4·NUM_DIGITS: currently captured value, registered.
- `blink_phase` out 1: 0 = visible half, 1 = blanked half.

## Operation
- State:
  - `value_r` holds the captured value.
  - `mask_r` holds the captured blink mask.
  - `div_cnt` is `$clog2(BLINK_DIV)` bits, minimum 1.
  - `phase_r` is the blink phase.
  - `seg_r` is the registered segment output.
- Divider:
  - `div_cnt` counts 0..BLINK_DIV-1.
  - At BLINK_DIV-1 it wraps to 0 and `phase_r` toggles.
  - With BLINK_DIV=1, `phase_r` toggles every cycle.
- Load:
  - `value_r`←`value` and `mask_r`←`blink_en`.
  - `div_cnt`←0 and `phase_r`←0, so a new value is always shown immediately.
  - Load takes priority over a simultaneous divider wrap.
  - Back-to-back loads are legal; the last one wins.
- Digit encoding (0–F): 40,79,24,30,19,12,02,78,00,18,08,03,46,21,06,0E hex. Blank = 7F.
- Per digit i, the next `seg_r` is blank if `phase_r`=1 and `mask_r[i]`=1, or if blanked by LZ (see Configuration). Otherwise it is the encoded nibble of `value_r`.
- Reset values:
  - `value_r`=0, `mask_r`=0, `div_cnt`=0, `phase_r`=0.
  - `seg` = every digit 7'h40. With LZ enabled, digit 0 = 40 and all others 7F.
  - `shown_value`=0, `blink_phase`=0.
- Reset asserted mid-blink or mid-load forces all of the above immediately, without waiting for a clock edge.

## Timing
- `load` sampled at edge k → `shown_value` updates at k. `seg` reflects the new value at edge k+1, giving 1-cycle segment latency.
- A phase toggle at edge k → the blinking digits change at k+1.
- After a load at edge k, the first blank half starts with `seg` at edge k+1+BLINK_DIV. Visible and blank halves then alternate, each BLINK_DIV cycles long.
- There is no backpressure: `load` is accepted in any cycle.

## Configuration
- `SEG7_LZ_BLANK_EN`:
  - Defined: digit i (i≥1) is blanked whenever nibbles i..NUM_DIGITS-1 of `value_r` are all zero. Digit 0 is never LZ-blanked. Blink blanking still applies on top.
  - Undefined: all digits always show their nibble, including leading zeros.

## Structure
- Package `seg7_pkg` holds:
  - `SEG7_BLANK` = 7'h7F.
  - `seg7_t` = `logic [6:0]`.
  - the 16-entry encoding constant array.
- Sub-module `seg7_digit_enc`: combinational nibble→`seg7_t` lookup. It is instantiated NUM_DIGITS times via generate. All registering stays in the top module.

## Test plan
All scenarios use NUM_DIGITS=6 and BLINK_DIV=4.
1. Reset without LZ → `seg` = six digits of 40 and `blink_phase`=0. With `SEG7_LZ_BLANK_EN` → digits 5..1 = 7F and digit 0 = 40.
2. Load 24'h0123AF with mask 0 → one cycle later digits 5..0 = 40,79,24,30,08,0E. `shown_value`=0123AF on the load edge.
3. Load 24'h0123AF with mask 6'b000001 → digit 0 alternates 0E for 4 cycles and 7F for 4 cycles; digits 5..1 stay steady.
4. Assert `load` of 24'h00000F during `blink_phase`=1, on the same cycle the divider wraps → `blink_phase`=0 and `div_cnt`=0. Digit 0 = 0E on the next cycle, and the next blank half arrives 4 cycles later.
5. With `SEG7_LZ_BLANK_EN`, load 24'h000050 → digits 5..2 = 7F, digit 1 = 12, digit 0 = 40. Then load 0 → digits 5..1 = 7F and digit 0 = 40.
6. Assert `rst` asynchronously mid-blink, between clock edges → `seg`, `shown_value` and `blink_phase` reach their reset values before the next clock edge.
